// File: rtl/rom_boot_copier.sv
// rtl/rom_boot_copier.sv - boot ROM to destination copy engine with skid FIFO
// Optional checksum port pair enabled by defining ROM_COPY_CHECKSUM_EN.
module rom_boot_copier #(
    parameter int ROM_DEPTH  = 2560,
    parameter int ROM_AW     = 12,
    parameter int DST_AW     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ROM_AW-1:0] src_base,
    input  logic [ROM_AW:0]   word_count,
    input  logic [DST_AW-1:0] dst_base,
    output logic [ROM_AW-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    input  logic [31:0]       rom_readdata,
    output logic [DST_AW-1:0] dst_address,
    output logic              dst_write,
    output logic [31:0]       dst_writedata,
    output logic [3:0]        dst_byteenable,
    input  logic              dst_waitrequest,
`ifdef ROM_COPY_CHECKSUM_EN
    output logic [31:0]       checksum,
    input  logic [31:0]       expected_sum,
`endif
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [ROM_AW+1:0] ROM_LIMIT  = (ROM_AW+2)'(ROM_DEPTH);
    localparam logic [CW-1:0]     FIFO_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW:0]       FILL_LIMIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [ROM_AW:0]   CNT_ONE    = (ROM_AW+1)'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] src_addr_q, src_addr_d;
    logic [ROM_AW:0]   reads_left_q, reads_left_d;
    logic [ROM_AW:0]   writes_left_q, writes_left_d;
    logic [DST_AW-1:0] dst_addr_q, dst_addr_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       fifo_mem_q [FIFO_DEPTH];
    logic [31:0]       fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     fifo_count_q, fifo_count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       checksum_q, checksum_d;

    logic [ROM_AW+1:0] range_sum;
    logic              cmd_ok;
    logic              pop;
    logic              issue;
    logic [CW:0]       fill_after_pop;
    logic [31:0]       head;
    logic [31:0]       sum_next;
    logic              sum_bad;
    logic              unused_ok;

    // The two low destination address bits are forced to zero on latch.
    assign unused_ok = &{1'b0, dst_base[1:0]};

    // Command check, FIFO occupancy and read-issue decision.
    always_comb begin
        range_sum = (ROM_AW+2)'(src_base) + (ROM_AW+2)'(word_count);
        cmd_ok    = (word_count != '0) && (range_sum <= ROM_LIMIT);
        head      = fifo_mem_q[rd_ptr_q];
        pop       = (fifo_count_q != '0) && !dst_waitrequest;
        // A pop this cycle frees a slot, which keeps the stream at one word per clock.
        fill_after_pop = {1'b0, fifo_count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue = (state_q == S_RUN) && (reads_left_q != '0) &&
                (fifo_count_q != FIFO_FULL) && (fill_after_pop < FILL_LIMIT);
        sum_next = checksum_q + head;
`ifdef ROM_COPY_CHECKSUM_EN
        sum_bad = (sum_next != expected_sum);
`else
        sum_bad = 1'b0;
`endif
    end

    // Next-state for the FSM, counters, FIFO and registered status outputs.
    always_comb begin
        state_d       = state_q;
        src_addr_d    = src_addr_q;
        reads_left_d  = reads_left_q;
        writes_left_d = writes_left_q;
        dst_addr_d    = dst_addr_q;
        inflight_d    = issue;
        fifo_mem_d    = fifo_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_count_d  = fifo_count_q + CW'(inflight_q) - CW'(pop);
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        checksum_d    = checksum_q;

        if (inflight_q) begin
            fifo_mem_d[wr_ptr_q] = rom_readdata;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd_ok) begin
                        state_d       = S_RUN;
                        src_addr_d    = src_base;
                        reads_left_d  = word_count;
                        writes_left_d = word_count;
                        dst_addr_d    = {dst_base[DST_AW-1:2], 2'b00};
                        busy_d        = 1'b1;
                        checksum_d    = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    src_addr_d   = src_addr_q + ROM_AW'(1);
                    reads_left_d = reads_left_q - CNT_ONE;
                end
                if (pop) begin
                    dst_addr_d    = dst_addr_q + DST_AW'(4);
                    writes_left_d = writes_left_q - CNT_ONE;
                    checksum_d    = sum_next;
                    if (writes_left_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        error_d = sum_bad;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state registers; reset aborts any copy at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            src_addr_q    <= '0;
            reads_left_q  <= '0;
            writes_left_q <= '0;
            dst_addr_q    <= '0;
            inflight_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            checksum_q    <= '0;
        end else begin
            state_q       <= state_d;
            src_addr_q    <= src_addr_d;
            reads_left_q  <= reads_left_d;
            writes_left_q <= writes_left_d;
            dst_addr_q    <= dst_addr_d;
            inflight_q    <= inflight_d;
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            checksum_q    <= checksum_d;
        end
    end

    assign rom_chipselect = issue;
    assign rom_clken      = issue;
    assign rom_address    = issue ? src_addr_q : '0;
    assign dst_write      = (fifo_count_q != '0);
    assign dst_writedata  = head;
    assign dst_address    = dst_addr_q;
    assign dst_byteenable = 4'hF;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
`ifdef ROM_COPY_CHECKSUM_EN
    assign checksum       = checksum_q;
`else
    logic unused_sum;
    assign unused_sum = &{1'b0, checksum_q};
`endif

endmodule

// File: tb/tb_rom_boot_copier.sv
// tb/tb_rom_boot_copier.sv - directed self-checking bench for rom_boot_copier
module tb_rom_boot_copier;

    localparam int ROM_DEPTH = 2560;
    localparam int ROM_AW    = 12;
    localparam int DST_AW    = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] src_base = '0;
    logic [ROM_AW:0]   word_count = '0;
    logic [DST_AW-1:0] dst_base = '0;
    logic [ROM_AW-1:0] rom_address;
    logic              rom_chipselect;
    logic              rom_clken;
    logic [31:0]       rom_readdata = '0;
    logic [DST_AW-1:0] dst_address;
    logic              dst_write;
    logic [31:0]       dst_writedata;
    logic [3:0]        dst_byteenable;
    logic              dst_waitrequest = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
`ifdef ROM_COPY_CHECKSUM_EN
    logic [31:0]       checksum;
    logic [31:0]       expected_sum = '0;
`endif

    always #5 clk = ~clk;

    rom_boot_copier dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .src_base        (src_base),
        .word_count      (word_count),
        .dst_base        (dst_base),
        .rom_address     (rom_address),
        .rom_chipselect  (rom_chipselect),
        .rom_clken       (rom_clken),
        .rom_readdata    (rom_readdata),
        .dst_address     (dst_address),
        .dst_write       (dst_write),
        .dst_writedata   (dst_writedata),
        .dst_byteenable  (dst_byteenable),
        .dst_waitrequest (dst_waitrequest),
`ifdef ROM_COPY_CHECKSUM_EN
        .checksum        (checksum),
        .expected_sum    (expected_sum),
`endif
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    logic [31:0] rom_mem [ROM_DEPTH];

    always @(posedge clk) begin
        if (rom_chipselect && rom_clken) rom_readdata <= rom_mem[rom_address];
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor state
    int          cyc = 0;
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc [$];
    int          rom_reads, last_rom, max_rom;
    int          done_cnt, done_cyc, err_cnt, err_cyc, start_cyc;
    int          stall_err, occ, max_occ, cs_full_err;
    logic        iss_prev, prev_stall, acc;
    logic [31:0] prev_a, prev_d;
    bit          bp_mode = 0;
    int          stall_cnt = 0;

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        rom_reads = 0; last_rom = -1; max_rom = -1;
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        stall_err = 0; max_occ = 0; cs_full_err = 0;
    endtask

    // Back-pressure driver plus bus monitor with a bench-side FIFO occupancy model.
    always @(negedge clk) begin
        if (bp_mode && dst_write && stall_cnt < 3) begin
            dst_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            dst_waitrequest = 1'b0;
            stall_cnt = 0;
        end
        #1;
        cyc++;
        if (start) start_cyc = cyc;
        if (rom_chipselect && rom_clken) begin
            rom_reads++;
            last_rom = int'(rom_address);
            if (int'(rom_address) > max_rom) max_rom = int'(rom_address);
        end
        acc = dst_write && !dst_waitrequest;
        if (acc) begin
            wr_addr.push_back(dst_address);
            wr_data.push_back(dst_writedata);
            wr_cyc.push_back(cyc);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (!reset_n) begin
            occ = 0; iss_prev = 1'b0; prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!dst_write || dst_address != prev_a || dst_writedata != prev_d))
                stall_err++;
            prev_stall = dst_write && dst_waitrequest;
            prev_a = dst_address;
            prev_d = dst_writedata;
            if (occ > max_occ) max_occ = occ;
            if (occ >= 2 && rom_chipselect) cs_full_err++;
            occ = occ + int'(iss_prev) - int'(acc);
            iss_prev = rom_chipselect;
        end
    end

    task automatic send(input int src, input int wc, input logic [31:0] dst);
        @(negedge clk);
        src_base = ROM_AW'(src);
        word_count = (ROM_AW+1)'(wc);
        dst_base = dst;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done_cnt != 0 || err_cnt != 0) break;
        end
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic check_writes(input string tag, input int n, input int src, input logic [31:0] dst);
        check({tag, "_nwr"}, wr_data.size(), n);
        for (int i = 0; i < n && i < wr_data.size(); i++) begin
            check({tag, "_addr"}, wr_addr[i], dst + 32'(4 * i));
            check({tag, "_data"}, wr_data[i], rom_mem[src + i]);
        end
    endtask

    initial begin
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 32'hA500_0000 | 32'(i);
        rom_mem[16] = 32'h1111_1111;
        rom_mem[17] = 32'h2222_2222;
        rom_mem[18] = 32'h3333_3333;
        rom_mem[19] = 32'h4444_4444;
        rom_mem[96] = 32'd1;
        rom_mem[97] = 32'd2;
        rom_mem[98] = 32'd3;
        clear_logs();

        // reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cs", rom_chipselect, 0);
        check("rst_clken", rom_clken, 0);
        check("rst_dst_write", dst_write, 0);
        check("rst_dst_addr", dst_address, 0);
        check("rst_byteen", dst_byteenable, 4'hF);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // basic copy
        clear_logs();
        send(16, 4, 32'h0000_1000);
        wait_end(50);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_err", err_cnt, 0);
        check("basic_nwr", wr_data.size(), 4);
        for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
            check("basic_addr", wr_addr[i], 32'h1000 + 32'(4 * i));
            check("basic_data", wr_data[i], 32'h1111_1111 * 32'(i + 1));
        end
        if (wr_cyc.size() == 4) begin
            check("basic_first_wr_lat", wr_cyc[0] - start_cyc, 3);
            check("basic_consecutive", wr_cyc[3] - wr_cyc[0], 3);
            check("basic_done_lat", done_cyc - wr_cyc[3], 1);
        end
        check("basic_rom_reads", rom_reads, 4);
        check("basic_last_rom", last_rom, 19);
        check("basic_busy_after", busy, 0);

        // back-pressure
        clear_logs();
        bp_mode = 1;
        send(16, 4, 32'h0000_1000);
        wait_end(200);
        bp_mode = 0;
        check("bp_done_cnt", done_cnt, 1);
        check_writes("bp", 4, 16, 32'h1000);
        check("bp_stable", stall_err, 0);
        check("bp_max_fifo", max_occ, 2);
        check("bp_cs_full", cs_full_err, 0);
        check("bp_rom_reads", rom_reads, 4);
        if (wr_cyc.size() == 4) check("bp_stall_spacing", wr_cyc[1] - wr_cyc[0], 4);

        // range: last legal window
        clear_logs();
        send(2556, 4, 32'h0000_2003);
        wait_end(50);
        check("hi_done_cnt", done_cnt, 1);
        check("hi_err", err_cnt, 0);
        check("hi_last_rom", last_rom, 2559);
        check("hi_max_rom", max_rom, 2559);
        check_writes("hi", 4, 2556, 32'h2000);

        // range: one past the end
        clear_logs();
        send(2557, 4, 32'h0000_3000);
        wait_end(20);
        check("ovr_err_cnt", err_cnt, 1);
        check("ovr_err_lat", err_cyc - start_cyc, 1);
        check("ovr_done", done_cnt, 0);
        check("ovr_rom_reads", rom_reads, 0);
        check("ovr_nwr", wr_data.size(), 0);

        // range: zero length
        clear_logs();
        send(5, 0, 32'h0000_3000);
        wait_end(20);
        check("zero_err_cnt", err_cnt, 1);
        check("zero_rom_reads", rom_reads, 0);
        check("zero_nwr", wr_data.size(), 0);

        // start while busy is ignored
        clear_logs();
        send(32, 6, 32'h0000_4000);
        @(negedge clk);
        send(256, 5, 32'h0000_9000);
        wait_end(60);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_err", err_cnt, 0);
        check("ign_rom_reads", rom_reads, 6);
        check_writes("ign", 6, 32, 32'h4000);

        // reset mid-copy, then a clean copy
        clear_logs();
        bp_mode = 1;
        send(64, 8, 32'h0000_5000);
        for (int i = 0; i < 100 && wr_data.size() < 2; i++) @(negedge clk);
        check("mid_two_writes", wr_data.size(), 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_cs", rom_chipselect, 0);
        check("mid_dst_write", dst_write, 0);
        check("mid_dst_addr", dst_address, 0);
        check("mid_byteen", dst_byteenable, 4'hF);
        bp_mode = 0;
        clear_logs();
        repeat (3) @(negedge clk);
        check("mid_quiet_rom", rom_reads, 0);
        check("mid_quiet_wr", wr_data.size(), 0);
        reset_n = 1'b1;
        clear_logs();
        send(80, 8, 32'h0000_6000);
        wait_end(60);
        check("post_done_cnt", done_cnt, 1);
        check("post_err", err_cnt, 0);
        check("post_rom_reads", rom_reads, 8);
        check_writes("post", 8, 80, 32'h6000);

`ifdef ROM_COPY_CHECKSUM_EN
        // checksum match
        clear_logs();
        expected_sum = 32'd6;
        send(96, 3, 32'h0000_7000);
        wait_end(40);
        check("cs_ok_done", done_cnt, 1);
        check("cs_ok_err", err_cnt, 0);
        check("cs_ok_sum", checksum, 32'd6);

        // checksum mismatch
        clear_logs();
        expected_sum = 32'd7;
        send(96, 3, 32'h0000_7000);
        wait_end(40);
        check("cs_bad_done", done_cnt, 1);
        check("cs_bad_err", err_cnt, 1);
        check("cs_bad_coincide", err_cyc - done_cyc, 0);
        check("cs_bad_sum", checksum, 32'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
